// File: rtl/fp_decode_pipe.sv
// Two-stage pipelined IEEE-754 field decoder with valid/ready handshake.
// S1 captures fields and class flags; S2 normalises denormals and drives registered outputs.
module fp_decode_pipe #(
    parameter int EXP_W     = 8,
    parameter int MAN_W     = 23,
    parameter int NORMALIZE = 1,
    localparam int FW       = 1 + EXP_W + MAN_W,
    localparam int XW       = EXP_W + 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FW-1:0]    fp_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sign_out,
    output logic [XW-1:0]    exp_out,
    output logic [MAN_W:0]   man_out,
    output logic             is_zero,
    output logic             is_inf,
    output logic             is_nan,
    output logic             is_snan,
    output logic             is_denormal
);

    localparam logic [XW-1:0] BIAS_X     = XW'((2 ** (EXP_W - 1)) - 1);
    localparam logic [XW-1:0] ONE_X      = XW'(1);
    localparam logic [XW-1:0] DEN_EXP_X  = ONE_X - BIAS_X;
    localparam logic [XW-1:0] NEG_BIAS_X = XW'(0) - BIAS_X;

    // Class vector layout: {zero, inf, nan, snan, denormal}
    logic                v1_q, v1_d;
    logic                s1_sign_q, s1_sign_d;
    logic [EXP_W-1:0]    s1_exp_q, s1_exp_d;
    logic [MAN_W-1:0]    s1_man_q, s1_man_d;
    logic [4:0]          s1_cls_q, s1_cls_d;

    logic                v2_q, v2_d;
    logic                s2_sign_q, s2_sign_d;
    logic [XW-1:0]       s2_exp_q, s2_exp_d;
    logic [MAN_W:0]      s2_man_q, s2_man_d;
    logic [4:0]          s2_cls_q, s2_cls_d;

    logic                adv1, adv2;
    logic [EXP_W-1:0]    in_e;
    logic [MAN_W-1:0]    in_m;
    logic                e_zero, e_ones, m_nz;
    logic [EXP_W-1:0]    lz;

    // Leading-zero count of the stored mantissa; only meaningful for nonzero input.
    function automatic logic [EXP_W-1:0] lzc(input logic [MAN_W-1:0] m);
        logic [EXP_W-1:0] n;
        logic             found;
        n     = '0;
        found = 1'b0;
        for (int i = MAN_W - 1; i >= 0; i--) begin
            if (m[i]) begin
                found = 1'b1;
            end else if (!found) begin
                n = n + EXP_W'(1);
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    assign adv2     = !v2_q || out_ready;
    assign adv1     = !v1_q || adv2;
    assign in_ready = adv1;

    assign in_e   = fp_in[FW-2 -: EXP_W];
    assign in_m   = fp_in[MAN_W-1:0];
    assign e_zero = ~|in_e;
    assign e_ones = &in_e;
    assign m_nz   = |in_m;
    assign lz     = lzc(s1_man_q);

    // S1 next state: capture fields and classify on a transfer, otherwise hold.
    always_comb begin
        v1_d      = v1_q;
        s1_sign_d = s1_sign_q;
        s1_exp_d  = s1_exp_q;
        s1_man_d  = s1_man_q;
        s1_cls_d  = s1_cls_q;
        if (adv1) begin
            v1_d = in_valid;
            if (in_valid) begin
                s1_sign_d = fp_in[FW-1];
                s1_exp_d  = in_e;
                s1_man_d  = in_m;
                s1_cls_d  = {e_zero && !m_nz, e_ones && !m_nz, e_ones && m_nz,
                             e_ones && m_nz && !in_m[MAN_W-1], e_zero && m_nz};
            end else begin
                s1_cls_d = s1_cls_q;
            end
        end else begin
            v1_d = v1_q;
        end
    end

    // S2 next state: unbiased exponent and mantissa with hidden bit, normalising denormals.
    always_comb begin
        v2_d      = v2_q;
        s2_sign_d = s2_sign_q;
        s2_exp_d  = s2_exp_q;
        s2_man_d  = s2_man_q;
        s2_cls_d  = s2_cls_q;
        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                s2_sign_d = s1_sign_q;
                s2_cls_d  = s1_cls_q;
                if (s1_cls_q[4]) begin
                    s2_exp_d = '0;
                    s2_man_d = '0;
                end else if (s1_cls_q[0]) begin
                    if (NORMALIZE != 0) begin
                        // 1-BIAS-(L+1) == -BIAS-L
                        s2_exp_d = NEG_BIAS_X - {{(XW-EXP_W){1'b0}}, lz};
                        s2_man_d = {1'b0, s1_man_q} << (lz + EXP_W'(1));
                    end else begin
                        s2_exp_d = DEN_EXP_X;
                        s2_man_d = {1'b0, s1_man_q};
                    end
                end else if (s1_cls_q[3]) begin
                    s2_exp_d = {2'b00, s1_exp_q} - BIAS_X;
                    s2_man_d = '0;
                end else if (s1_cls_q[2]) begin
                    s2_exp_d = {2'b00, s1_exp_q} - BIAS_X;
                    s2_man_d = {1'b0, s1_man_q};
                end else begin
                    s2_exp_d = {2'b00, s1_exp_q} - BIAS_X;
                    s2_man_d = {1'b1, s1_man_q};
                end
            end else begin
                s2_cls_d = s2_cls_q;
            end
        end else begin
            v2_d = v2_q;
        end
    end

    // Pipeline registers with synchronous reset that drops all in-flight words.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q      <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_exp_q  <= '0;
            s1_man_q  <= '0;
            s1_cls_q  <= 5'b00000;
            v2_q      <= 1'b0;
            s2_sign_q <= 1'b0;
            s2_exp_q  <= '0;
            s2_man_q  <= '0;
            s2_cls_q  <= 5'b00000;
        end else begin
            v1_q      <= v1_d;
            s1_sign_q <= s1_sign_d;
            s1_exp_q  <= s1_exp_d;
            s1_man_q  <= s1_man_d;
            s1_cls_q  <= s1_cls_d;
            v2_q      <= v2_d;
            s2_sign_q <= s2_sign_d;
            s2_exp_q  <= s2_exp_d;
            s2_man_q  <= s2_man_d;
            s2_cls_q  <= s2_cls_d;
        end
    end

    assign out_valid = v2_q;
    assign sign_out  = s2_sign_q;
    assign exp_out   = s2_exp_q;
    assign man_out   = s2_man_q;
    assign {is_zero, is_inf, is_nan, is_snan, is_denormal} = s2_cls_q;

endmodule

// File: tb/tb_fp_decode_pipe.sv
// Bench for fp_decode_pipe: FP32 (normalising and legacy) and FP16 instances sharing one handshake,
// each checked against a value-level reference model through a scoreboard queue.
module tb_fp_decode_pipe;

    typedef struct packed {
        logic               s;
        logic signed [31:0] ex;
        logic [31:0]        man;
        logic [4:0]         fl;
    } res_t;

    logic        clk, rst, in_valid, out_ready;
    logic [31:0] fa, fb;
    logic [15:0] fc;
    logic [2:0]  rdy, vld;
    logic        s_a, s_b, s_c;
    logic [9:0]  ex_a, ex_b;
    logic [6:0]  ex_c;
    logic [23:0] mn_a, mn_b;
    logic [10:0] mn_c;
    logic [4:0]  f_a, f_b, f_c;

    int checks   = 0;
    int failures = 0;

    fp_decode_pipe #(.EXP_W(8), .MAN_W(23), .NORMALIZE(1)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .fp_in(fa),
        .out_valid(vld[0]), .out_ready(out_ready), .sign_out(s_a), .exp_out(ex_a), .man_out(mn_a),
        .is_zero(f_a[4]), .is_inf(f_a[3]), .is_nan(f_a[2]), .is_snan(f_a[1]), .is_denormal(f_a[0]));
    fp_decode_pipe #(.EXP_W(8), .MAN_W(23), .NORMALIZE(0)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .fp_in(fb),
        .out_valid(vld[1]), .out_ready(out_ready), .sign_out(s_b), .exp_out(ex_b), .man_out(mn_b),
        .is_zero(f_b[4]), .is_inf(f_b[3]), .is_nan(f_b[2]), .is_snan(f_b[1]), .is_denormal(f_b[0]));
    fp_decode_pipe #(.EXP_W(5), .MAN_W(10), .NORMALIZE(1)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .fp_in(fc),
        .out_valid(vld[2]), .out_ready(out_ready), .sign_out(s_c), .exp_out(ex_c), .man_out(mn_c),
        .is_zero(f_c[4]), .is_inf(f_c[3]), .is_nan(f_c[2]), .is_snan(f_c[1]), .is_denormal(f_c[0]));

    res_t o[3];
    assign o[0] = '{s: s_a, ex: 32'($signed(ex_a)), man: 32'(mn_a), fl: f_a};
    assign o[1] = '{s: s_b, ex: 32'($signed(ex_b)), man: 32'(mn_b), fl: f_b};
    assign o[2] = '{s: s_c, ex: 32'($signed(ex_c)), man: 32'(mn_c), fl: f_c};

    int     cfg_ew [3] = '{8, 8, 5};
    int     cfg_mw [3] = '{23, 23, 10};
    int     cfg_nr [3] = '{1, 0, 1};
    longint fpv [3];
    assign fpv[0] = longint'(fa);
    assign fpv[1] = longint'(fb);
    assign fpv[2] = longint'(fc);

    res_t q [3][$];
    res_t prev [3];
    bit   stall_p [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: decode by value, normalising by repeated doubling.
    function automatic res_t model(input int ew, input int mw, input int nr, input longint fp);
        res_t   r;
        longint e, m, bias, emax, man, ex;
        e    = (fp >> mw) & ((64'sd1 <<< ew) - 1);
        m    = fp & ((64'sd1 <<< mw) - 1);
        bias = (64'sd1 <<< (ew - 1)) - 1;
        emax = (64'sd1 <<< ew) - 1;
        r.s  = 1'((fp >> (ew + mw)) & 1);
        r.fl = 5'b00000;
        if (e == 0 && m == 0) begin
            ex = 0; man = 0; r.fl = 5'b10000;
        end else if (e == 0) begin
            r.fl = 5'b00001;
            man  = m;
            ex   = 1 - bias;
            if (nr != 0) begin
                while (man < (64'sd1 <<< mw)) begin
                    man = man * 2;
                    ex  = ex - 1;
                end
            end
        end else if (e == emax) begin
            ex  = e - bias;
            man = m;
            if (m == 0) r.fl = 5'b01000;
            else if (((m >> (mw - 1)) & 1) == 0) r.fl = 5'b00110;
            else r.fl = 5'b00100;
        end else begin
            ex  = e - bias;
            man = m + (64'sd1 <<< mw);
        end
        r.ex  = 32'(ex);
        r.man = 32'(man);
        return r;
    endfunction

    function automatic longint gen(input int ew, input int mw);
        longint e, m, s, emax;
        emax = (64'sd1 <<< ew) - 1;
        case ($urandom_range(0, 3))
            0:       e = 0;
            1:       e = emax;
            default: e = longint'($urandom_range(1, 32'(emax - 1)));
        endcase
        m = longint'($urandom) & ((64'sd1 <<< mw) - 1);
        if ($urandom_range(0, 1) == 1) m = m >> $urandom_range(0, mw);
        s = longint'($urandom_range(0, 1));
        return (s <<< (ew + mw)) | (e <<< mw) | m;
    endfunction

    // Scoreboard / protocol monitor, sampled mid-cycle.
    always @(negedge clk) begin
        int   cnt;
        res_t e;
        if (rst) begin
            for (int d = 0; d < 3; d++) begin
                q[d].delete();
                stall_p[d] = 1'b0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                cnt = q[d].size();
                chk($sformatf("d%0d_in_ready", d), rdy[d], (cnt == 2 && !out_ready) ? 0 : 1);
                if (cnt == 0) chk($sformatf("d%0d_idle_valid", d), vld[d], 0);
                if (stall_p[d]) begin
                    chk($sformatf("d%0d_stall_hold", d), o[d], prev[d]);
                    chk($sformatf("d%0d_stall_valid", d), vld[d], 1);
                end
                if (vld[d] && out_ready) begin
                    if (cnt == 0) begin
                        chk($sformatf("d%0d_spurious_out", d), 1, 0);
                    end else begin
                        e = q[d].pop_front();
                        chk($sformatf("d%0d_sign", d), o[d].s, e.s);
                        chk($sformatf("d%0d_exp", d), o[d].ex, e.ex);
                        chk($sformatf("d%0d_man", d), o[d].man, e.man);
                        chk($sformatf("d%0d_flags", d), o[d].fl, e.fl);
                    end
                end
                if (in_valid && rdy[d])
                    q[d].push_back(model(cfg_ew[d], cfg_mw[d], cfg_nr[d], fpv[d]));
                stall_p[d] = vld[d] && !out_ready;
                prev[d]    = o[d];
            end
        end
    end

    task automatic expect_out(input int d, input string tag, input int s, input int ex,
                              input longint man, input int fl);
        chk({tag, "_valid"}, vld[d], 1);
        chk({tag, "_sign"}, o[d].s, s);
        chk({tag, "_exp"}, o[d].ex, ex);
        chk({tag, "_man"}, o[d].man, man);
        chk({tag, "_flags"}, o[d].fl, fl);
    endtask

    // Single word with out_ready high; returns when the result should be on the outputs.
    task automatic send_one(input logic [31:0] a, input logic [31:0] b, input logic [15:0] c);
        @(posedge clk); #1;
        in_valid = 1'b1; fa = a; fb = b; fc = c;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("latency_early", vld, 3'b000);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; fa = '0; fb = '0; fc = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_valid", vld, 3'b000);
        chk("rst_ready", rdy, 3'b111);
        chk("rst_data", {s_a, ex_a, mn_a, f_a}, 0);

        send_one(32'h3F80_0000, 32'h3F80_0000, 16'h3C00);
        expect_out(0, "one32", 0, 0, 64'h80_0000, 5'b00000);
        expect_out(2, "one16", 0, 0, 64'h400, 5'b00000);
        send_one(32'h0000_0001, 32'h0000_0001, 16'h0001);
        expect_out(0, "den32", 0, -149, 64'h80_0000, 5'b00001);
        expect_out(1, "den32_nonorm", 0, -126, 64'h1, 5'b00001);
        expect_out(2, "den16", 0, -24, 64'h400, 5'b00001);
        send_one(32'h8000_0000, 32'h7F80_0000, 16'h7C00);
        expect_out(0, "negzero", 1, 0, 0, 5'b10000);
        expect_out(1, "inf32", 0, 128, 0, 5'b01000);
        expect_out(2, "inf16", 0, 16, 0, 5'b01000);
        send_one(32'h7FC0_0000, 32'h7F80_0001, 16'h8000);
        expect_out(0, "qnan", 0, 128, 64'h40_0000, 5'b00100);
        expect_out(1, "snan", 0, 128, 64'h1, 5'b00110);
        expect_out(2, "negzero16", 1, 0, 0, 5'b10000);

        // Random traffic with random backpressure.
        repeat (600) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            fa = 32'(gen(8, 23));
            fb = 32'(gen(8, 23));
            fc = 16'(gen(5, 10));
        end

        // Continuous stream with out_ready pattern 1,0,0,1.
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            in_valid  = 1'b1;
            out_ready = (i % 4 == 0) || (i % 4 == 3);
            fa = 32'(gen(8, 23));
            fb = 32'(gen(8, 23));
            fc = 16'(gen(5, 10));
        end

        // Drain, then two words in flight and a one-cycle reset.
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        in_valid = 1'b1; fa = 32'h4000_0000; fb = 32'h4040_0000; fc = 16'h4000;
        @(posedge clk); #1;
        fa = 32'h4080_0000; fb = 32'h40A0_0000; fc = 16'h4400;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        chk("midrst_valid", vld, 3'b000);
        chk("midrst_ready", rdy, 3'b111);
        repeat (6) @(posedge clk);

        // Final drain with a bounded wait.
        #1;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (q[0].size() + q[1].size() + q[2].size() != 0) @(posedge clk);
        end
        @(negedge clk);
        chk("drain_empty", q[0].size() + q[1].size() + q[2].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
